// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC register and next-PC sequencer with valid/ready fetch and pending redirect.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc_o,
    input  logic [31:0]      pc_plus4_i,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             redirect_ack_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);
    localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, REDIR_WAIT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d, pend_q, pend_d, tgt;
    logic             pend_mis_q, pend_mis_d, ack_q, ack_d, mis_q, mis_d, tgt_mis, fire;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef PC_MISALIGN_TRAP_EN
    assign tgt_mis = |redirect_pc_i[1:0];
    assign tgt     = tgt_mis ? TRAP_VECTOR : redirect_pc_i;
`else
    assign tgt_mis = 1'b0;
    assign tgt     = redirect_pc_i & ~32'd3;
`endif

    assign fetch_valid_o  = (state_q == RUN) || (state_q == REDIR_WAIT);
    assign fire           = fetch_valid_o && fetch_ready_i;
    assign pc_o           = pc_q;
    assign redirect_ack_o = ack_q;
    assign misalign_o     = mis_q;
    assign fetch_cnt_o    = cnt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_mis_d = pend_mis_q;
        ack_d      = 1'b0;
        mis_d      = 1'b0;
        cnt_d      = fire ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_i && fire) begin
                    pc_d    = tgt;
                    ack_d   = 1'b1;
                    mis_d   = tgt_mis;
                    state_d = stall_i ? STALL : RUN;
                end else if (redirect_i) begin
                    pend_d     = tgt;
                    pend_mis_d = tgt_mis;
                    state_d    = REDIR_WAIT;
                end else if (fire) begin
                    pc_d    = pc_plus4_i;
                    state_d = stall_i ? STALL : RUN;
                end
            end
            REDIR_WAIT: begin
                // a redirect arriving on the firing edge supersedes the buffered one
                if (fire) begin
                    pc_d    = redirect_i ? tgt : pend_q;
                    ack_d   = 1'b1;
                    mis_d   = redirect_i ? tgt_mis : pend_mis_q;
                    state_d = stall_i ? STALL : RUN;
                end else if (redirect_i) begin
                    pend_d     = tgt;
                    pend_mis_d = tgt_mis;
                end
            end
            STALL: begin
                if (redirect_i) begin
                    pc_d  = tgt;
                    ack_d = 1'b1;
                    mis_d = tgt_mis;
                end
                state_d = stall_i ? STALL : RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pend_mis_q <= 1'b0;
            ack_q      <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_mis_q <= pend_mis_d;
            ack_q      <= ack_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and next-PC sequencer for the fetch stage.
- Drives the current PC to the downstream pc_plus4 incrementer and takes back its PC+4 result.
- Selects between sequential, redirect (branch/jump) and hold.
- Presents the fetch address to instruction memory over a valid/ready handshake, with stall handling and a one-entry pending-redirect buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- TRAP_VECTOR, 32'h0000_0100, target used for misaligned redirects (optional feature only).
- CNT_W, 16, width of the accepted-fetch counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_o  out  32  current PC; feeds pc_plus4 and instruction-memory address.
- pc_plus4_i  in  32  PC+4 returned by pc_plus4 (combinational from pc_o).
- fetch_valid_o  out  1  fetch request valid; address is pc_o.
- fetch_ready_i  in  1  instruction memory accepts request.
- stall_i  in  1  downstream stall; blocks new requests.
- redirect_i  in  1  one-cycle redirect strobe.
- redirect_pc_i  in  32  redirect target.
- redirect_ack_o  out  1  pulse: redirect target loaded into pc_o.
- misalign_o  out  1  pulse: misaligned redirect trapped (optional feature).
- fetch_cnt_o  out  CNT_W  count of accepted fetches (fire = valid & ready).

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc_o=RESET_PC, fetch_valid_o=0, redirect_ack_o=0, misalign_o=0, fetch_cnt_o=0.
  - Pending-redirect register cleared; state=BOOT.
  - Reset asserted mid-operation discards any pending redirect and in-flight request.
- States: BOOT, RUN, STALL, REDIR_WAIT.
- fetch_valid_o=1 in RUN and REDIR_WAIT; 0 in BOOT and STALL. It is a registered state decode, never combinational from stall_i.
- Handshake rule: while fetch_valid_o=1 and fetch_ready_i=0, pc_o and fetch_valid_o hold stable.
- BOOT: first edge after rst_n release goes to RUN; pc_o stays RESET_PC. First request visible one cycle after reset release.
- RUN, resolved in this priority on each edge:
  - redirect_i & fire: pc_o<=target, redirect_ack_o=1 next cycle. Next state STALL if stall_i, else RUN.
  - redirect_i & !fire: target latched into pending register, pc_o held, state REDIR_WAIT.
  - fire & stall_i: pc_o<=pc_plus4_i, state STALL.
  - fire: pc_o<=pc_plus4_i, stay RUN.
  - no fire: hold.
- REDIR_WAIT:
  - A further redirect_i overwrites the pending target (newest wins).
  - On fire: pc_o<=pending target (or the new redirect_pc_i if redirect_i in the same cycle), redirect_ack_o=1. Next state STALL if stall_i, else RUN.
- STALL:
  - redirect_i: pc_o<=target immediately, redirect_ack_o=1.
  - stall_i=0 at the edge: go to RUN.
  - Stall and redirect in the same cycle: redirect loads PC, state stays STALL.
- Target = redirect_pc_i with bits[1:0] forced to 0 (default build).
- Wrap-around: pc_plus4_i is used unmodified; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- fetch_cnt_o increments by 1 on every fire and wraps modulo 2^CNT_W.
- redirect_ack_o and misalign_o are single-cycle registered pulses.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined: a redirect target with bits[1:0]!=0 is replaced by TRAP_VECTOR. misalign_o pulses in the same cycle as redirect_ack_o. The pending register stores the already-resolved target.
- Undefined: low bits are silently cleared and misalign_o is tied 0.

Test Plan:
- Reset then fetch_ready_i=1 constant, stall_i=0 -> fetch_valid_o rises one cycle after rst_n release. pc_o sequence is 0x0, 0x4, 0x8, 0xC. fetch_cnt_o=4 after 4 fires.
- fetch_ready_i=0 for 3 cycles at pc_o=0x10 -> pc_o stays 0x10 and fetch_valid_o stays 1. After ready returns, next pc_o=0x14.
- redirect_i with redirect_pc_i=0x200 while ready=0, then a second redirect 0x300 before ready -> pc_o holds until fire, then becomes 0x300. One redirect_ack_o pulse.
- stall_i=1 at fire of 0x20 -> pc_o=0x24 and fetch_valid_o=0 while stalled. Redirect to 0x80 during stall -> pc_o=0x80. On stall release, the request issues at 0x80.
- pc_o forced to 0xFFFF_FFFC via redirect, then fire -> pc_o=0x0000_0000. fetch_cnt_o wraps 0xFFFF->0x0000 with CNT_W=16.
- With PC_MISALIGN_TRAP_EN: redirect_pc_i=0x202 -> pc_o=0x100, misalign_o=1 for one cycle. Without the macro: pc_o=0x200, misalign_o=0.
